// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared helpers for the ADC deserialiser/packer
// Provides the constant log2 used for pointer/level sizing and the test-pattern generator.
package adc_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Caller truncates to the sample width, which gives the modulo wrap.
  function automatic logic [31:0] pattern(input logic [15:0] seq, input int ch);
    return 32'(seq) + 32'(ch);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO
// Head word is held in a register so the consumer sees a flop output, not a RAM read path.
module sync_fifo_fwft
  import adc_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   ready_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   valid_o,
  output logic [clog2(DEPTH):0]  level_o,
  output logic                   full_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full, pop, push_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign pop     = valid_q & ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push_i & (~full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    head_d   = head_q;
    if (push_ok && ((level_q - LW'(pop)) == '0)) begin
      head_d = push_data_i;
    end else if (pop) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= (level_d != '0);
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign full_o  = full;

endmodule

// File: rtl/adc_deser_pack.sv
// rtl/adc_deser_pack.sv - N-channel serial ADC deserialiser, frame packer and output FIFO
// Each conversion yields one frame; frames are dropped and counted when the FIFO cannot take them.
module adc_deser_pack
  import adc_pkg::*;
#(
  parameter int N_CH     = 17,
  parameter int SAMPLE_W = 15,
  parameter int OUT_W    = 256,
  parameter int DEPTH    = 128,
  parameter int OVF_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [N_CH-1:0]        bit_i,
  input  logic [N_CH-1:0]        ch_mask_i,
  input  logic                   test_en_i,
  output logic [OUT_W-1:0]       m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [clog2(DEPTH):0]  level_o,
  output logic                   full_o,
  output logic [OVF_W-1:0]       ovf_cnt_o,
  output logic                   frame_err_o,
  output logic [15:0]            frame_cnt_o
);

  localparam int FRAME_W = N_CH * SAMPLE_W;
  localparam int CW      = (clog2(SAMPLE_W) < 1) ? 1 : clog2(SAMPLE_W);

  if (OUT_W < FRAME_W) begin : g_bad_out_w
    $error("adc_deser_pack: OUT_W must be >= N_CH*SAMPLE_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("adc_deser_pack: DEPTH must be a power of two >= 2");
  end

  logic [CW-1:0]       bit_cnt_q;
  logic [SAMPLE_W-1:0] sh_q     [N_CH];
  logic [SAMPLE_W-1:0] sample_d [N_CH];
  logic [SAMPLE_W-1:0] field_d  [N_CH];
  logic [OUT_W-1:0]    frame_q, frame_d;
  logic                push_q;
  logic                frame_err_q;
  logic [15:0]         frame_cnt_q;
  logic [OVF_W-1:0]    ovf_cnt_q;
  logic                last_bit;
  logic                fifo_full;
  logic                fifo_valid;
  logic                pop;

  assign last_bit = valid_i && (bit_cnt_q == CW'(SAMPLE_W - 1));
  assign pop      = fifo_valid & m_ready_i;

  // Unused MSBs above FRAME_W stay zero because frame_d starts cleared.
  always_comb begin
    frame_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      sample_d[c] = (sh_q[c] << 1) | SAMPLE_W'(bit_i[c]);
      field_d[c]  = test_en_i ? SAMPLE_W'(pattern(frame_cnt_q, c)) : sample_d[c];
      if (!ch_mask_i[c]) field_d[c] = '0;
      frame_d[SAMPLE_W*c +: SAMPLE_W] = field_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      ovf_cnt_q   <= '0;
      for (int c = 0; c < N_CH; c++) sh_q[c] <= '0;
    end else begin
      push_q <= 1'b0;
      if (valid_i) begin
        for (int c = 0; c < N_CH; c++) sh_q[c] <= sample_d[c];
        if (last_bit) begin
          bit_cnt_q   <= '0;
          frame_q     <= frame_d;
          push_q      <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
      end else if (bit_cnt_q != '0) begin
        // valid dropped mid-conversion: discard the partial sample set.
        bit_cnt_q   <= '0;
        frame_err_q <= 1'b1;
      end
      if (push_q && fifo_full && !pop && (ovf_cnt_q != '1)) begin
        ovf_cnt_q <= ovf_cnt_q + OVF_W'(1);
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_q),
    .push_data_i (frame_q),
    .ready_i     (m_ready_i),
    .head_o      (m_data_o),
    .valid_o     (fifo_valid),
    .level_o     (level_o),
    .full_o      (fifo_full)
  );

  assign m_valid_o   = fifo_valid;
  assign full_o      = fifo_full;
  assign ovf_cnt_o   = ovf_cnt_q;
  assign frame_err_o = frame_err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_adc_deser_pack.sv
// tb/tb_adc_deser_pack.sv - self-checking bench for adc_deser_pack
// A queue-based frame model runs alongside the DUT; directed scenarios add fixed expectations.
module tb_adc_deser_pack;

  localparam int NCH = 17;
  localparam int SW  = 15;
  localparam int OW  = 256;
  localparam int DP  = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i;
  logic [NCH-1:0] bit_i;
  logic [NCH-1:0] ch_mask_i;
  logic          test_en_i;
  logic [OW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [7:0]    level_o;
  logic          full_o;
  logic [15:0]   ovf_cnt_o;
  logic          frame_err_o;
  logic [15:0]   frame_cnt_o;

  adc_deser_pack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .bit_i       (bit_i),
    .ch_mask_i   (ch_mask_i),
    .test_en_i   (test_en_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .level_o     (level_o),
    .full_o      (full_o),
    .ovf_cnt_o   (ovf_cnt_o),
    .frame_err_o (frame_err_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: conversions become integer samples, frames live in a queue.
  logic [OW-1:0] mq[$];
  logic [OW-1:0] m_frame;
  int  m_acc [NCH];
  int  m_cnt, m_fcnt, m_ovf;
  bit  m_err, m_pend;

  task automatic model_step();
    int  sz;
    bit  pop;
    int  v;
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0; m_fcnt = 0; m_ovf = 0; m_err = 0; m_pend = 0;
      return;
    end
    sz  = mq.size();
    pop = (sz > 0) && m_ready_i;
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      if (sz < DP || pop) mq.push_back(m_frame);
      else if (m_ovf < 65535) m_ovf++;
    end
    m_pend = 0;
    if (valid_i) begin
      for (int c = 0; c < NCH; c++) begin
        if (m_cnt == 0) m_acc[c] = 0;
        m_acc[c] = (m_acc[c] * 2 + int'(bit_i[c])) % (1 << SW);
      end
      m_cnt++;
      if (m_cnt == SW) begin
        m_frame = '0;
        for (int c = 0; c < NCH; c++) begin
          if (!ch_mask_i[c]) v = 0;
          else if (test_en_i) v = (m_fcnt + c) % (1 << SW);
          else v = m_acc[c];
          m_frame[SW*c +: SW] = SW'(v);
        end
        m_pend = 1;
        m_fcnt = (m_fcnt + 1) % 65536;
        m_cnt  = 0;
      end
    end else if (m_cnt != 0) begin
      m_err = 1;
      m_cnt = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("m_valid", OW'(m_valid_o), OW'(mq.size() > 0));
    check("level", OW'(level_o), OW'(mq.size()));
    check("full", OW'(full_o), OW'(mq.size() == DP));
    check("ovf_cnt", OW'(ovf_cnt_o), OW'(m_ovf));
    check("frame_err", OW'(frame_err_o), OW'(m_err));
    check("frame_cnt", OW'(frame_cnt_o), OW'(m_fcnt));
    if (mq.size() > 0) check("head", m_data_o, mq[0]);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // Stimulus
  logic [SW-1:0] cv [NCH];
  bit rnd_ready = 0;

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) m_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_conv(input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      valid_i = 1'b1;
      for (int c = 0; c < NCH; c++) bit_i[c] = cv[c][SW-1-i];
    end
    tick();
    valid_i = 1'b0;
    bit_i   = '0;
  endtask

  task automatic rand_cv();
    for (int c = 0; c < NCH; c++) cv[c] = SW'($urandom);
  endtask

  task automatic drain(input int n);
    m_ready_i = 1'b1;
    repeat (n) tick();
    m_ready_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, OW'(m_valid_o), '0);
    check({tag, "_level"}, OW'(level_o), '0);
    check({tag, "_full"}, OW'(full_o), '0);
    check({tag, "_ovf"}, OW'(ovf_cnt_o), '0);
    check({tag, "_err"}, OW'(frame_err_o), '0);
    check({tag, "_fcnt"}, OW'(frame_cnt_o), '0);
    check({tag, "_data"}, m_data_o, '0);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; bit_i = '0; ch_mask_i = '1;
    test_en_i = 1'b0; m_ready_i = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Known samples, two edges from last bit to visible head
    for (int c = 0; c < NCH; c++) cv[c] = SW'(16'h100 + c);
    send_conv(SW);
    tick();
    check("lat_valid", OW'(m_valid_o), OW'(1));
    check("lat_level", OW'(level_o), OW'(1));
    for (int c = 0; c < NCH; c++) check($sformatf("known_f%0d", c), OW'(m_data_o[SW*c +: SW]), OW'(16'h100 + c));
    check("bit255", OW'(m_data_o[OW-1]), '0);
    drain(3);

    // Test pattern with channel 0 masked at frame_cnt 5
    m_ready_i = 1'b1;
    repeat (4) begin rand_cv(); send_conv(SW); end
    drain(3);
    check("fcnt5", OW'(frame_cnt_o), OW'(5));
    test_en_i = 1'b1; ch_mask_i = 17'h1FFFE;
    send_conv(SW);
    tick();
    check("tp_f0", OW'(m_data_o[0 +: SW]), OW'(0));
    check("tp_f1", OW'(m_data_o[SW +: SW]), OW'(6));
    check("tp_f16", OW'(m_data_o[SW*16 +: SW]), OW'(21));
    test_en_i = 1'b0; ch_mask_i = '1;
    drain(3);

    // Truncated conversion followed by a full one
    rand_cv(); send_conv(7);
    rand_cv(); send_conv(SW);
    tick();
    check("trunc_err", OW'(frame_err_o), OW'(1));
    check("trunc_level", OW'(level_o), OW'(1));
    check("trunc_fcnt", OW'(frame_cnt_o), OW'(7));
    for (int c = 0; c < NCH; c++) check($sformatf("trunc_f%0d", c), OW'(m_data_o[SW*c +: SW]), OW'(cv[c]));
    drain(3);

    // Fill past capacity; field 0 carries the frame sequence number
    test_en_i = 1'b1;
    repeat (130) begin rand_cv(); send_conv(SW); end
    tick();
    check("fill_full", OW'(full_o), OW'(1));
    check("fill_level", OW'(level_o), OW'(DP));
    check("fill_ovf", OW'(ovf_cnt_o), OW'(2));
    rand_cv(); send_conv(SW);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    tick();
    check("pp_ovf", OW'(ovf_cnt_o), OW'(2));
    check("pp_level", OW'(level_o), OW'(DP));
    m_ready_i = 1'b1;
    for (int k = 0; k < DP - 1; k++) begin
      check($sformatf("order_%0d", k), OW'(m_data_o[0 +: SW]), OW'(8 + k));
      tick();
    end
    check("order_last", OW'(m_data_o[0 +: SW]), OW'(137));
    tick();
    m_ready_i = 1'b0;
    tick();
    check("drain_level", OW'(level_o), '0);
    test_en_i = 1'b0;

    // Reset mid-conversion with three frames queued
    repeat (3) begin rand_cv(); send_conv(SW); end
    tick();
    check("pre_rst_level", OW'(level_o), OW'(3));
    rand_cv();
    for (int i = 0; i < 7; i++) begin
      tick(); valid_i = 1'b1;
      for (int c = 0; c < NCH; c++) bit_i[c] = cv[c][SW-1-i];
    end
    tick(); valid_i = 1'b0; bit_i = '0; rst_n = 1'b0;
    tick();
    check_zero_outputs("midrst");
    rst_n = 1'b1;
    rand_cv(); send_conv(SW);
    tick();
    check("post_rst_level", OW'(level_o), OW'(1));
    check("post_rst_err", OW'(frame_err_o), '0);
    for (int c = 0; c < NCH; c++) check($sformatf("post_rst_f%0d", c), OW'(m_data_o[SW*c +: SW]), OW'(cv[c]));
    drain(3);

    // Randomised traffic against the model
    rnd_ready = 1;
    repeat (80) begin
      rand_cv();
      ch_mask_i = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
      test_en_i = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) send_conv($urandom_range(1, SW - 1));
      else send_conv(SW);
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_ready = 0;
    drain(150);
    check("final_level", OW'(level_o), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
